// File: rtl/sr_ff_cmd_driver.sv
// Command-to-pulse driver for an SR flip-flop: turns set/clear requests into
// a single legal S or R pulse, then confirms the result on q/qbar feedback.
module sr_ff_cmd_driver #(
    parameter int PULSE_W = 1,
    parameter int GAP     = 1,
    parameter int TIMEOUT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cmd_valid,
    input  logic cmd_set,
    output logic cmd_ready,
    input  logic q_fb,
    input  logic qbar_fb,
    output logic s,
    output logic r,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int M1   = (PULSE_W > GAP) ? PULSE_W : GAP;
    localparam int MAXV = (M1 > TIMEOUT) ? M1 : TIMEOUT;
    localparam int CW   = $clog2(MAXV + 1);

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] PW_LAST  = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_CONFIRM,
        ST_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tgt_q, tgt_d;
    logic          s_q, s_d;
    logic          r_q, r_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          match;
    state_t        post_st;

    // Equal q/qbar (illegal or unknown) can never satisfy both terms.
    assign match   = (q_fb == tgt_q) && (qbar_fb == ~tgt_q);
    assign post_st = (GAP == 0) ? ST_IDLE : ST_GAP;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tgt_q   <= 1'b0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            s_q     <= s_d;
            r_q     <= r_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        s_d     = s_q;
        r_d     = r_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    tgt_d   = cmd_set;
                    cnt_d   = PW_LAST;
                    s_d     = cmd_set;
                    r_d     = ~cmd_set;
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    s_d     = 1'b0;
                    r_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_CONFIRM;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            ST_CONFIRM: begin
                if (match) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = post_st;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = post_st;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign s         = s_q;
    assign r         = r_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sr_ff_cmd_driver.sv
// Bench for sr_ff_cmd_driver: three instances (default, PULSE_W=3, GAP=2),
// each driving a behavioural SR flip-flop whose q/qbar is fed back.
module tb_sr_ff_cmd_driver;

    typedef struct {
        int inst;
        bit is_err;
        bit q;
    } exp_t;

    exp_t sb[$];

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] vld = '0;
    logic       set_c = 1'b0;
    logic       hold0 = 1'b0;
    logic [2:0] ffq = '0;
    logic [2:0] qfb, qbfb;
    logic [2:0] rdy, s_o, r_o, bsy, dn, er;
    int         cyc = 0;
    int         n_assert = 0;
    int         n_fail = 0;
    bit         started = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (s_o[i] && !r_o[i]) ffq[i] <= 1'b1;
            else if (r_o[i] && !s_o[i]) ffq[i] <= 1'b0;
        end
    end

    assign qfb[0]  = hold0 ? 1'b0 : ffq[0];
    assign qbfb[0] = hold0 ? 1'b1 : ~ffq[0];
    assign qfb[2:1]  = ffq[2:1];
    assign qbfb[2:1] = ~ffq[2:1];

    sr_ff_cmd_driver u_def (
        .clk(clk), .rst(rst), .cmd_valid(vld[0]), .cmd_set(set_c),
        .cmd_ready(rdy[0]), .q_fb(qfb[0]), .qbar_fb(qbfb[0]),
        .s(s_o[0]), .r(r_o[0]), .busy(bsy[0]), .done(dn[0]), .err(er[0])
    );

    sr_ff_cmd_driver #(.PULSE_W(3)) u_pw3 (
        .clk(clk), .rst(rst), .cmd_valid(vld[1]), .cmd_set(set_c),
        .cmd_ready(rdy[1]), .q_fb(qfb[1]), .qbar_fb(qbfb[1]),
        .s(s_o[1]), .r(r_o[1]), .busy(bsy[1]), .done(dn[1]), .err(er[1])
    );

    sr_ff_cmd_driver #(.GAP(2)) u_gap2 (
        .clk(clk), .rst(rst), .cmd_valid(vld[2]), .cmd_set(set_c),
        .cmd_ready(rdy[2]), .q_fb(qfb[2]), .qbar_fb(qbfb[2]),
        .s(s_o[2]), .r(r_o[2]), .busy(bsy[2]), .done(dn[2]), .err(er[2])
    );

    // Invariants on every cycle once out of the first reset.
    always @(negedge clk) begin
        if (started && rst) begin
            n_assert++;
            if ((s_o & r_o) !== 3'b000) begin
                n_fail++;
                $display("FAIL s_and_r: s=%b r=%b required s&r=000", s_o, r_o);
            end
            n_assert++;
            if ((dn & er) !== 3'b000) begin
                n_fail++;
                $display("FAIL done_and_err: done=%b err=%b required none together", dn, er);
            end
        end
    end

    task automatic wait_evt(input int i, output bit got, output int at);
        got = 1'b0;
        at  = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (dn[i] || er[i]) begin
                got = 1'b1;
                at  = cyc;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        vld = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        started = 1'b1;
        n_assert++;
        if (s_o !== 3'b000 || r_o !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_sr: s=%b r=%b required 000/000", s_o, r_o);
        end
        n_assert++;
        if (dn !== 3'b000 || er !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_done_err: done=%b err=%b required 000/000", dn, er);
        end
        n_assert++;
        if (rdy !== 3'b111 || bsy !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ready: ready=%b busy=%b required 111/000", rdy, bsy);
        end
    endtask

    task automatic test_set();
        bit   got;
        int   at, e0;
        exp_t ex;
        set_c  = 1'b1;
        vld[0] = 1'b1;
        sb.push_back('{0, 1'b0, 1'b1});
        @(negedge clk);
        e0 = cyc;
        vld[0] = 1'b0;
        n_assert++;
        if (s_o[0] !== 1'b1 || r_o[0] !== 1'b0 || rdy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL set_pulse: s=%b r=%b ready=%b required 1/0/0",
                     s_o[0], r_o[0], rdy[0]);
        end
        @(negedge clk);
        n_assert++;
        if (s_o[0] !== 1'b0 || dn[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL set_pulse_end: s=%b done=%b required 0/0", s_o[0], dn[0]);
        end
        wait_evt(0, got, at);
        n_assert++;
        if (!got) begin
            n_fail++;
            $display("FAIL set_timeout: no done/err within budget");
            return;
        end
        n_assert++;
        if (at - e0 !== 2 || dn[0] !== 1'b1 || rdy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL set_done_lat: lat=%0d done=%b ready=%b required 2/1/0",
                     at - e0, dn[0], rdy[0]);
        end
        ex = sb.pop_front();
        n_assert++;
        if (er[0] !== ex.is_err || ffq[0] !== ex.q || ex.inst != 0) begin
            n_fail++;
            $display("FAIL set_result: err=%b q=%b required err=%b q=%b",
                     er[0], ffq[0], ex.is_err, ex.q);
        end
        @(negedge clk);
        n_assert++;
        if (rdy[0] !== 1'b1 || dn[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL set_ready_back: ready=%b done=%b required 1/0", rdy[0], dn[0]);
        end
    endtask

    task automatic test_clear_pw3();
        bit   got;
        int   at, rcnt, scnt, extra;
        exp_t ex;
        set_c  = 1'b1;
        vld[1] = 1'b1;
        sb.push_back('{1, 1'b0, 1'b1});
        @(negedge clk);
        vld[1] = 1'b0;
        wait_evt(1, got, at);
        n_assert++;
        if (!got) begin
            n_fail++;
            $display("FAIL pw3_set_timeout: no done/err within budget");
            return;
        end
        ex = sb.pop_front();
        n_assert++;
        if (er[1] !== ex.is_err || ffq[1] !== ex.q) begin
            n_fail++;
            $display("FAIL pw3_set_result: err=%b q=%b required %b/%b",
                     er[1], ffq[1], ex.is_err, ex.q);
        end
        repeat (3) @(negedge clk);
        set_c  = 1'b0;
        vld[1] = 1'b1;
        sb.push_back('{1, 1'b0, 1'b0});
        rcnt = 0;
        scnt = 0;
        got  = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            vld[1] = 1'b0;
            if (dn[1] || er[1]) begin
                got = 1'b1;
                break;
            end
            if (r_o[1]) rcnt++;
            if (s_o[1]) scnt++;
        end
        n_assert++;
        if (!got) begin
            n_fail++;
            $display("FAIL pw3_clear_timeout: no done/err within budget");
            return;
        end
        n_assert++;
        if (rcnt != 3 || scnt != 0) begin
            n_fail++;
            $display("FAIL pw3_width: r_cycles=%0d s_cycles=%0d required 3/0", rcnt, scnt);
        end
        ex = sb.pop_front();
        n_assert++;
        if (er[1] !== ex.is_err || ffq[1] !== ex.q) begin
            n_fail++;
            $display("FAIL pw3_clear_result: err=%b q=%b required %b/%b",
                     er[1], ffq[1], ex.is_err, ex.q);
        end
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (dn[1] || er[1]) extra++;
        end
        n_assert++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL pw3_done_once: extra_events=%0d required 0", extra);
        end
    endtask

    task automatic test_timeout();
        bit   got;
        int   at, e0;
        exp_t ex;
        hold0  = 1'b1;
        set_c  = 1'b1;
        vld[0] = 1'b1;
        sb.push_back('{0, 1'b1, 1'b0});
        @(negedge clk);
        e0 = cyc;
        vld[0] = 1'b0;
        wait_evt(0, got, at);
        n_assert++;
        if (!got) begin
            n_fail++;
            $display("FAIL to_timeout: no err within budget");
            hold0 = 1'b0;
            return;
        end
        ex = sb.pop_front();
        n_assert++;
        if (er[0] !== ex.is_err || dn[0] !== 1'b0 || at - e0 !== 5) begin
            n_fail++;
            $display("FAIL to_err: err=%b done=%b lat=%0d required %b/0/5",
                     er[0], dn[0], at - e0, ex.is_err);
        end
        n_assert++;
        if (s_o[0] !== 1'b0 || r_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL to_sr_idle: s=%b r=%b required 0/0", s_o[0], r_o[0]);
        end
        @(negedge clk);
        n_assert++;
        if (er[0] !== 1'b0 || dn[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL to_err_once: err=%b done=%b required 0/0", er[0], dn[0]);
        end
        hold0 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit   got;
        int   acc;
        exp_t ex;
        vld[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_c = (k % 2 == 0);
            sb.push_back('{2, 1'b0, (k % 2 == 0)});
            acc = rdy[2] ? 1 : 0;
            got = 1'b0;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                if (dn[2] || er[2]) begin
                    got = 1'b1;
                    break;
                end
                if (rdy[2]) acc++;
            end
            n_assert++;
            if (!got) begin
                n_fail++;
                $display("FAIL b2b_timeout: cmd %0d no done/err", k);
                vld[2] = 1'b0;
                return;
            end
            n_assert++;
            if (acc != 1) begin
                n_fail++;
                $display("FAIL b2b_accepts: cmd %0d ready_cycles=%0d required 1", k, acc);
            end
            ex = sb.pop_front();
            n_assert++;
            if (er[2] !== ex.is_err || ffq[2] !== ex.q) begin
                n_fail++;
                $display("FAIL b2b_result: cmd %0d err=%b q=%b required %b/%b",
                         k, er[2], ffq[2], ex.is_err, ex.q);
            end
            n_assert++;
            if (rdy[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_gap0: cmd %0d ready=%b required 0", k, rdy[2]);
            end
            @(negedge clk);
            n_assert++;
            if (rdy[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_gap1: cmd %0d ready=%b required 0", k, rdy[2]);
            end
            @(negedge clk);
            n_assert++;
            if (rdy[2] !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready: cmd %0d ready=%b required 1", k, rdy[2]);
            end
        end
        vld[2] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int ev;
        set_c  = 1'b1;
        vld[1] = 1'b1;
        @(negedge clk);
        vld[1] = 1'b0;
        n_assert++;
        if (s_o[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_pulse: s=%b required 1", s_o[1]);
        end
        rst = 1'b0;
        @(negedge clk);
        n_assert++;
        if (s_o[1] !== 1'b0 || r_o[1] !== 1'b0 || rdy[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_abort: s=%b r=%b ready=%b required 0/0/1",
                     s_o[1], r_o[1], rdy[1]);
        end
        rst = 1'b1;
        ev  = 0;
        repeat (8) begin
            @(negedge clk);
            if (dn[1] || er[1] || s_o[1] || !rdy[1]) ev++;
        end
        n_assert++;
        if (ev != 0) begin
            n_fail++;
            $display("FAIL rm_quiet: bad_cycles=%0d required 0", ev);
        end
    endtask

    initial begin
        test_reset();
        test_set();
        test_clear_pw3();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        n_assert++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_left: pending=%0d required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
